mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 14, the word-address width (16384 words).
REQ-002 SHALL have parameter DWIDTH, default 32, the data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 8, the maximum number of consecutive conflict cycles in which requester B may lose under fixed priority.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have ports a_req_valid (in, 1), a_req_ready (out, 1), a_req_addr (in, AWIDTH), a_req_we (in, DWIDTH/8), a_req_wdata (in, DWIDTH): the CPU data-port request channel.
REQ-007 SHALL have ports a_resp_valid (out, 1) and a_resp_rdata (out, DWIDTH): the CPU response channel.
REQ-008 SHALL have ports b_req_valid, b_req_ready, b_req_addr, b_req_we, b_req_wdata, b_resp_valid and b_resp_rdata, with the same widths as the A ports: the program-loader/debug channel.
REQ-009 SHALL have ports mem_en (out, 1), mem_we (out, DWIDTH/8), mem_addr (out, AWIDTH), mem_din (out, DWIDTH) and mem_dout (in, DWIDTH): a single-port memory with 1-cycle synchronous read.
REQ-010 SHALL have ports a_grant_cnt, b_grant_cnt and conflict_cnt, each out, 32 bits: performance counters.

Function
REQ-011 SHALL grant at most one request per cycle; a grant is the handshake x_req_valid && x_req_ready in the same cycle.
REQ-012 SHALL derive x_req_ready combinationally, in the same cycle, from both valids and the priority state.
REQ-013 SHALL, when exactly one requester is valid, grant that requester.
REQ-014 SHALL, when neither requester is valid, hold mem_en=0 and mem_we=0.
REQ-015 SHALL, on a grant, drive mem_en=1 and copy the granted requester's addr, we and wdata to mem_addr, mem_we and mem_din combinationally in the same cycle.
REQ-016 SHALL, exactly one cycle after any grant (read or write), assert the granted requester's x_resp_valid for one cycle, with x_resp_rdata=mem_dout.
REQ-017 SHALL track the owner of each outstanding response in a registered owner field; the other requester's resp_valid SHALL stay 0.
REQ-018 SHALL return responses to each requester in the same order as that requester's grants.
REQ-019 SHALL allow back-to-back grants every cycle with no bubble.
REQ-020 SHALL, under fixed priority, grant A on a conflict (both valid) unless the starve counter equals STARVE_LIMIT, in which case it SHALL grant B.
REQ-021 SHALL increment the starve counter on each conflict cycle that B loses, and clear it on a B grant or when b_req_valid=0.
REQ-022 SHALL increment a_grant_cnt and b_grant_cnt by one per grant to A and B respectively.
REQ-023 SHALL increment conflict_cnt by one per cycle in which both requesters are valid.
REQ-024 SHALL saturate all three counters at 32'hFFFF_FFFF.
REQ-025 SHALL not modify the memory for a request that is not granted, and SHALL require the requester to hold its request stable until granted.

Reset
REQ-026 SHALL, while rst=1, drive a_req_ready, b_req_ready, mem_en, mem_we, a_resp_valid and b_resp_valid to 0.
REQ-027 SHALL reset all counters, the starve counter and the priority state to 0, with last grant set to B so that A wins the first round-robin conflict.
REQ-028 SHALL, if rst is asserted in the cycle after a grant, discard that response: no resp_valid in that cycle or in the first cycle after rst deasserts.

Configuration
REQ-029 SHALL, when MEM_ARBITER_RR_EN is defined, resolve a conflict round-robin by granting the requester not granted most recently; the starve counter SHALL be absent and STARVE_LIMIT ignored.
REQ-030 SHALL, when MEM_ARBITER_RR_EN is undefined, use fixed priority A>B with the starvation override of REQ-020.

Verification
REQ-031 Bench SHALL cover: A write 0x1234_5678 to addr 0x010 with we=4'hF, then A read of 0x010 -> a_resp_valid one cycle after each grant; the read returns 0x1234_5678; b_resp_valid=0 throughout.
REQ-032 Bench SHALL cover: A and B both valid continuously for 20 cycles, macro undefined, STARVE_LIMIT=8 -> B is granted on conflict cycles 9 and 18, and conflict_cnt=20.
REQ-033 Bench SHALL cover: the same stimulus with MEM_ARBITER_RR_EN defined -> grants alternate A,B,A,..., and a_grant_cnt=10, b_grant_cnt=10.
REQ-034 Bench SHALL cover: B byte write we=4'b0010 with data 0x0000_AB00 onto a word holding 0xFFFF_FFFF -> a subsequent read returns 0xFFFF_ABFF.
REQ-035 Bench SHALL cover: rst asserted in the cycle after a B read grant -> b_resp_valid never asserts, and all counters read 0 after reset.
REQ-036 Bench SHALL cover: a_grant_cnt preloaded (via force) to 32'hFFFF_FFFE followed by 3 A grants -> a_grant_cnt=32'hFFFF_FFFF.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester arbiter in front of a single-port synchronous
//               memory with per-requester response routing and perf counters.
//               Define MEM_ARBITER_RR_EN for round-robin conflict resolution;
//               otherwise fixed priority A>B with a starvation override.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AWIDTH       = 14,
    parameter int DWIDTH       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [AWIDTH-1:0]     a_req_addr,
    input  logic [DWIDTH/8-1:0]   a_req_we,
    input  logic [DWIDTH-1:0]     a_req_wdata,
    output logic                  a_resp_valid,
    output logic [DWIDTH-1:0]     a_resp_rdata,

    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic [AWIDTH-1:0]     b_req_addr,
    input  logic [DWIDTH/8-1:0]   b_req_we,
    input  logic [DWIDTH-1:0]     b_req_wdata,
    output logic                  b_resp_valid,
    output logic [DWIDTH-1:0]     b_resp_rdata,

    output logic                  mem_en,
    output logic [DWIDTH/8-1:0]   mem_we,
    output logic [AWIDTH-1:0]     mem_addr,
    output logic [DWIDTH-1:0]     mem_din,
    input  logic [DWIDTH-1:0]     mem_dout,

    output logic [31:0]           a_grant_cnt,
    output logic [31:0]           b_grant_cnt,
    output logic [31:0]           conflict_cnt
);

    localparam int          c_be_w    = DWIDTH / 8;
    localparam logic [31:0] c_cnt_max = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    owner_e      owner_q, owner_d;
    logic        w_conflict;
    logic        w_b_priority;
    logic        w_grant_a;
    logic        w_grant_b;
    logic [31:0] a_grant_cnt_q, a_grant_cnt_d;
    logic [31:0] b_grant_cnt_q, b_grant_cnt_d;
    logic [31:0] conflict_cnt_q, conflict_cnt_d;

    assign w_conflict = a_req_valid & b_req_valid;

`ifdef MEM_ARBITER_RR_EN
    // Remembers whether B took the most recent grant; reset to B so A wins first.
    logic last_b_q, last_b_d;

    assign w_b_priority = ~last_b_q;

    always_comb begin
        last_b_d = last_b_q;
        if (w_grant_b) begin
            last_b_d = 1'b1;
        end else if (w_grant_a) begin
            last_b_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`else
    localparam int c_starve_w = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    logic [c_starve_w-1:0] starve_q, starve_d;

    assign w_b_priority = (starve_q == c_starve_max);

    // Counts consecutive conflicts lost by B; cannot pass the limit because
    // reaching it hands the next conflict to B, which clears it.
    always_comb begin
        starve_d = starve_q;
        if (!b_req_valid || w_grant_b) begin
            starve_d = '0;
        end else if (w_conflict) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`endif

    assign a_req_ready = ~rst & (~b_req_valid | ~w_b_priority);
    assign b_req_ready = ~rst & (~a_req_valid |  w_b_priority);
    assign w_grant_a   = a_req_valid & a_req_ready;
    assign w_grant_b   = b_req_valid & b_req_ready;

    always_comb begin
        mem_en   = w_grant_a | w_grant_b;
        mem_we   = {c_be_w{1'b0}};
        mem_addr = w_grant_b ? b_req_addr  : a_req_addr;
        mem_din  = w_grant_b ? b_req_wdata : a_req_wdata;
        if (w_grant_a) begin
            mem_we = a_req_we;
        end else if (w_grant_b) begin
            mem_we = b_req_we;
        end
    end

    always_comb begin
        owner_d = OWN_NONE;
        if (w_grant_a) begin
            owner_d = OWN_A;
        end else if (w_grant_b) begin
            owner_d = OWN_B;
        end
    end

    // Memory read latency is one cycle, so a single owner slot suffices.
    assign a_resp_valid = ~rst & (owner_q == OWN_A);
    assign b_resp_valid = ~rst & (owner_q == OWN_B);
    assign a_resp_rdata = mem_dout;
    assign b_resp_rdata = mem_dout;

    always_comb begin
        a_grant_cnt_d  = a_grant_cnt_q;
        b_grant_cnt_d  = b_grant_cnt_q;
        conflict_cnt_d = conflict_cnt_q;
        if (w_grant_a && (a_grant_cnt_q != c_cnt_max)) begin
            a_grant_cnt_d = a_grant_cnt_q + 32'd1;
        end
        if (w_grant_b && (b_grant_cnt_q != c_cnt_max)) begin
            b_grant_cnt_d = b_grant_cnt_q + 32'd1;
        end
        if (w_conflict && (conflict_cnt_q != c_cnt_max)) begin
            conflict_cnt_d = conflict_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q        <= OWN_NONE;
            a_grant_cnt_q  <= '0;
            b_grant_cnt_q  <= '0;
            conflict_cnt_q <= '0;
        end else begin
            owner_q        <= owner_d;
            a_grant_cnt_q  <= a_grant_cnt_d;
            b_grant_cnt_q  <= b_grant_cnt_d;
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign a_grant_cnt  = a_grant_cnt_q;
    assign b_grant_cnt  = b_grant_cnt_q;
    assign conflict_cnt = conflict_cnt_q;

endmodule

`default_nettype wire
